// File: rtl/maze_mem_arbiter_if.sv
// Bus bundle between the two maze solvers, the arbiter and the maze memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface maze_mem_arbiter_if #(
  parameter int maze_width = 6
);

  // Requester A
  logic                  req_a;
  logic [maze_width-1:0] row_a;
  logic [maze_width-1:0] col_a;
  logic                  oe_a;
  logic                  we_a;
  logic                  done_a;
  logic                  gnt_a;
  logic                  rvalid_a;
  logic                  rdata_a;

  // Requester B
  logic                  req_b;
  logic [maze_width-1:0] row_b;
  logic [maze_width-1:0] col_b;
  logic                  oe_b;
  logic                  we_b;
  logic                  done_b;
  logic                  gnt_b;
  logic                  rvalid_b;
  logic                  rdata_b;

  // Shared maze memory port
  logic [maze_width-1:0] mem_row;
  logic [maze_width-1:0] mem_col;
  logic                  mem_oe;
  logic                  mem_we;
  logic                  mem_in;

  // Status
  logic                  all_done;
  logic                  protocol_err;

  modport slave (
    input  req_a, row_a, col_a, oe_a, we_a, done_a,
    output gnt_a, rvalid_a, rdata_a,
    input  req_b, row_b, col_b, oe_b, we_b, done_b,
    output gnt_b, rvalid_b, rdata_b,
    output mem_row, mem_col, mem_oe, mem_we,
    input  mem_in,
    output all_done, protocol_err
  );

  modport master (
    output req_a, row_a, col_a, oe_a, we_a, done_a,
    input  gnt_a, rvalid_a, rdata_a,
    output req_b, row_b, col_b, oe_b, we_b, done_b,
    input  gnt_b, rvalid_b, rdata_b,
    input  mem_row, mem_col, mem_oe, mem_we,
    output mem_in,
    input  all_done, protocol_err
  );

endinterface

// File: rtl/maze_mem_arbiter.sv
// Round-robin arbiter sharing one maze memory port between two wall-follower
// solvers. One access is in flight at a time: IDLE samples requests, ISSUE
// drives the memory for one cycle, RESP waits for the registered read data.
module maze_mem_arbiter #(
  parameter int maze_width = 6
) (
  input  logic               clk,
  input  logic               rst,
  maze_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  typedef enum logic {
    WIN_A = 1'b0,
    WIN_B = 1'b1
  } winner_t;

  state_t                r_state;
  state_t                w_next_state;

  // Last granted requester. While an access is in ISSUE/RESP this is also the
  // owner of that access, so one register serves both roles.
  winner_t               r_last_winner;
  winner_t               w_pick;

  logic                  w_elig_a;
  logic                  w_elig_b;
  logic                  w_any_elig;
  logic                  w_grant_now;

  // Command registers latched from the winning requester in IDLE
  logic [maze_width-1:0] r_cmd_row;
  logic [maze_width-1:0] r_cmd_col;
  logic                  r_cmd_oe;
  logic                  r_cmd_we;
  logic                  w_cmd_read;
  logic                  w_cmd_bad;

  logic                  r_rvalid_a;
  logic                  r_rvalid_b;
  logic                  r_rdata_a;
  logic                  r_rdata_b;
  logic                  r_all_done;
  logic                  r_protocol_err;

  logic                  w_gnt_a;
  logic                  w_gnt_b;
  logic                  w_mem_oe;
  logic                  w_mem_we;

  // A requester that has declared done is invisible to arbitration.
  assign w_elig_a    = bus.req_a & ~bus.done_a;
  assign w_elig_b    = bus.req_b & ~bus.done_b;
  assign w_any_elig  = w_elig_a | w_elig_b;
  assign w_grant_now = (r_state == S_IDLE) && w_any_elig;

  // oe+we together is treated as a write; neither set moves no strobe.
  assign w_cmd_read  = r_cmd_oe & ~r_cmd_we;
  assign w_cmd_bad   = (r_cmd_oe == r_cmd_we);

  // Round-robin pick: a lone eligible requester wins, otherwise alternate.
  always_comb begin
    w_pick = WIN_A;
    if (w_elig_a && w_elig_b) begin
      w_pick = (r_last_winner == WIN_B) ? WIN_A : WIN_B;
    end else if (w_elig_b) begin
      w_pick = WIN_B;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      r_state <= w_next_state;
    end
  end

  // FSM next-state and grant/strobe outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    w_next_state = r_state;
    w_gnt_a      = 1'b0;
    w_gnt_b      = 1'b0;
    w_mem_oe     = 1'b0;
    w_mem_we     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_elig) begin
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_gnt_a      = (r_last_winner == WIN_A);
        w_gnt_b      = (r_last_winner == WIN_B);
        w_mem_oe     = w_cmd_read;
        w_mem_we     = r_cmd_we;
        w_next_state = w_cmd_read ? S_RESP : S_IDLE;
      end
      S_RESP: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Latch the winner's command and remember who won, on every grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_winner <= WIN_B;
      r_cmd_row     <= '0;
      r_cmd_col     <= '0;
      r_cmd_oe      <= 1'b0;
      r_cmd_we      <= 1'b0;
    end else if (w_grant_now) begin
      r_last_winner <= w_pick;
      if (w_pick == WIN_A) begin
        r_cmd_row <= bus.row_a;
        r_cmd_col <= bus.col_a;
        r_cmd_oe  <= bus.oe_a;
        r_cmd_we  <= bus.we_a;
      end else begin
        r_cmd_row <= bus.row_b;
        r_cmd_col <= bus.col_b;
        r_cmd_oe  <= bus.oe_b;
        r_cmd_we  <= bus.we_b;
      end
    end
  end

  // Capture read data during RESP; rvalid pulses in the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
      r_rdata_a  <= 1'b0;
      r_rdata_b  <= 1'b0;
    end else begin
      r_rvalid_a <= (r_state == S_RESP) && (r_last_winner == WIN_A);
      r_rvalid_b <= (r_state == S_RESP) && (r_last_winner == WIN_B);
      if ((r_state == S_RESP) && (r_last_winner == WIN_A)) begin
        r_rdata_a <= bus.mem_in;
      end
      if ((r_state == S_RESP) && (r_last_winner == WIN_B)) begin
        r_rdata_b <= bus.mem_in;
      end
    end
  end

  // Sticky status flags: malformed command seen, both solvers finished.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_protocol_err <= 1'b0;
      r_all_done     <= 1'b0;
    end else begin
      if ((r_state == S_ISSUE) && w_cmd_bad) begin
        r_protocol_err <= 1'b1;
      end
      if (bus.done_a && bus.done_b) begin
        r_all_done <= 1'b1;
      end
    end
  end

  // Address follows the command registers, so it holds outside ISSUE.
  assign bus.mem_row      = r_cmd_row;
  assign bus.mem_col      = r_cmd_col;
  assign bus.mem_oe       = w_mem_oe;
  assign bus.mem_we       = w_mem_we;

  assign bus.gnt_a        = w_gnt_a;
  assign bus.gnt_b        = w_gnt_b;
  assign bus.rvalid_a     = r_rvalid_a;
  assign bus.rvalid_b     = r_rvalid_b;
  assign bus.rdata_a      = r_rdata_a;
  assign bus.rdata_b      = r_rdata_b;

  assign bus.all_done     = r_all_done;
  assign bus.protocol_err = r_protocol_err;

endmodule

// File: doc/maze_mem_arbiter.md
Name: maze_mem_arbiter

Overview:
- Shares one maze memory port (row/col addressing, oe read strobe, we mark-write strobe, 1-bit read data) between two wall-follower solver requesters, A and B.
- Each solver issues one access at a time over a req/gnt handshake. Read data returns through a registered rvalid/rdata pair.
- Round-robin arbitration; a solver that has asserted its done is masked out.
- all_done tells the top level that both solvers have finished.

Parameters:
- maze_width, 6, width of the row and col coordinates on every port.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_a  in  1  requester A access request; held until gnt_a
- row_a, col_a  in  maze_width each  requester A cell coordinates
- oe_a  in  1  requester A read command
- we_a  in  1  requester A write (mark cell) command
- done_a  in  1  requester A finished; level, stays high
- gnt_a  out  1  one-cycle grant pulse to A
- rvalid_a  out  1  one-cycle read-data-valid to A
- rdata_a  out  1  read data to A; held until the next A read
- req_b, row_b, col_b, oe_b, we_b, done_b, gnt_b, rvalid_b, rdata_b  (same as A, for B)
- mem_row, mem_col  out  maze_width each  memory address
- mem_oe  out  1  memory read strobe
- mem_we  out  1  memory write strobe
- mem_in  in  1  memory read data; valid the cycle after mem_oe
- all_done  out  1  done_a AND done_b, registered
- protocol_err  out  1  sticky error flag

Behaviour:
- Reset: all outputs 0, state IDLE, last_winner = B (so A wins first). Async assertion drops mem_oe and mem_we immediately, including mid-read. A read in flight at reset is discarded; no rvalid follows.
- Eligibility: req_x AND NOT done_x.
- FSM states: IDLE, ISSUE, RESP.
- IDLE, at a clock edge:
  - If any requester is eligible, pick the winner, latch its row/col/oe/we into command registers, go to ISSUE.
  - Otherwise stay in IDLE.
- Round robin: if only one requester is eligible, it wins. If both are eligible, the one that is not last_winner wins. last_winner updates on every grant.
- ISSUE (exactly 1 cycle):
  - mem_row/mem_col/mem_oe/mem_we are driven from the command registers; gnt_winner = 1.
  - Latched write goes to IDLE; latched read goes to RESP.
  - Requests are not sampled in ISSUE.
- RESP (1 cycle):
  - mem_oe = 0, mem_we = 0.
  - mem_in is captured into rdata_winner at the end of the cycle.
  - rvalid_winner = 1 during the following cycle (the IDLE cycle); then go to IDLE.
- Requester rule: the requester drops req or presents a new command at the edge after gnt. Because the arbiter samples only in IDLE, there is no stale re-grant.
- Latency from req sampled to gnt: 1 cycle.
- Read occupancy: 3 cycles; rvalid arrives 2 cycles after gnt.
- Write occupancy: 2 cycles.
- Memory outputs outside ISSUE: mem_oe = mem_we = 0; mem_row/mem_col hold their last value.
- Command error: if the latched command has oe and we both 1, or both 0:
  - protocol_err is set and stays set until rst.
  - both = 1 is performed as a write only; both = 0 issues no strobe, but gnt is still given.
- done_x rising while req_x is held: request ignored from the next IDLE sample on. An access already in ISSUE or RESP completes normally.
- all_done is registered: set the cycle after both done_x are high, cleared only by rst.
- Command registers and the rdata registers are maze_width/1-bit wide; there is no arithmetic on coordinates.

Test Plan:
- Single read: rst released; req_a=1, row_a=5, col_a=7, oe_a=1; memory cell (5,7)=1.
  -> gnt_a and mem_oe high in cycle 1 with mem_row=5, mem_col=7; rvalid_a=1 and rdata_a=1 in cycle 3; B outputs stay 0.
- Contention: req_a and req_b held high continuously with writes, each dropping req for one edge after its gnt.
  -> grants go A, B, A, B, with gnt pulses 2 cycles apart; mem_we is asserted once per grant with the matching coordinates.
- Mixed traffic: A reads (2,2), B writes (3,3) in the same cycle.
  -> A is granted first; B's gnt and mem_we arrive in the cycle after A's rvalid; no overlap of mem_oe and mem_we.
- Done masking: done_a=1 while req_a=1, B idle.
  -> gnt_a never asserts. After done_b=1, all_done=1 one cycle later and stays high.
- Reset mid-read: rst asserted during the RESP cycle of an A read.
  -> mem_oe=0 and all outputs 0 immediately; no rvalid_a after release; the next grant goes to A.
- Protocol error: B issues a command with oe_b=1 and we_b=1.
  -> mem_we=1, mem_oe=0 in ISSUE; protocol_err=1 from the next cycle until rst.
